// File: rtl/mem_arbiter_if.sv
// Cache/RAM side bus of the memory arbiter: icache and dcache word ports plus the single RAM port.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // icache word port
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    // dcache word port
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    // shared RAM port
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    // error pulse
    logic              err;

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    // Caches and RAM side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache: dcache first, with a streak
// limit that lets a waiting icache through, and a watchdog that releases
// accesses the RAM never finishes.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned WDOG_W   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DSERV = 2'd1;
    localparam logic [1:0] ISERV = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [STREAK_W-1:0] r_streak;
    logic [WDOG_W-1:0]   r_wdog;   // 1 in the first serve cycle, 0 in IDLE
    logic                w_timeout;
    logic                w_d_done;
    logic                w_i_done;

    assign w_timeout = (r_wdog == WDOG_W'(TIMEOUT));

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and combinational bus outputs; an abort (strobes dropped)
    // beats any RAM status, and ERROR/timeout acks carry err with zero load
    always_comb begin
        w_next       = r_state;
        w_d_done     = 1'b0;
        w_i_done     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.err      = 1'b0;
        case (r_state)
            IDLE: begin
                if ((bus.dREN || bus.dWEN) &&
                    (!bus.iREN || (r_streak < STREAK_W'(MAX_D_STREAK))))
                    w_next = DSERV;
                else if (bus.iREN)
                    w_next = ISERV;
            end
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramREN   = bus.dREN && !bus.dWEN;
                bus.ramWEN   = bus.dWEN;
                if (bus.dREN && bus.dWEN && (r_wdog == WDOG_W'(1)))
                    bus.err = 1'b1;
                if (!bus.dREN && !bus.dWEN) begin
                    w_next = IDLE;
                end else if (bus.ramstate == RAM_ERROR || bus.ramstate == RAM_ACCESS || w_timeout) begin
                    w_next    = IDLE;
                    w_d_done  = 1'b1;
                    bus.dwait = 1'b0;
                    if (bus.ramstate != RAM_ACCESS)
                        bus.err = 1'b1;
                    else if (!bus.dWEN)
                        bus.dload = bus.ramload;
                end
            end
            ISERV: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                if (!bus.iREN) begin
                    w_next = IDLE;
                end else if (bus.ramstate == RAM_ERROR || bus.ramstate == RAM_ACCESS || w_timeout) begin
                    w_next    = IDLE;
                    w_i_done  = 1'b1;
                    bus.iwait = 1'b0;
                    if (bus.ramstate != RAM_ACCESS)
                        bus.err = 1'b1;
                    else
                        bus.iload = bus.ramload;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Consecutive dcache acks while icache is waiting
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_streak <= '0;
        end else if (w_d_done) begin
            if (!bus.iREN)
                r_streak <= '0;
            else if (r_streak != STREAK_W'(MAX_D_STREAK))
                r_streak <= r_streak + STREAK_W'(1);
        end else if (w_i_done) begin
            r_streak <= '0;
        end
    end

    // Watchdog: numbers the cycles of the current serve, cleared in IDLE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_wdog <= '0;
        else if (w_next == IDLE)
            r_wdog <= '0;
        else
            r_wdog <= r_wdog + WDOG_W'(1);
    end

endmodule
